// File: rtl/spectrum_peak_scan_if.sv
// RAM read port and peak-result bundle for spectrum_peak_scan.
// freq2/peak_mag2 are present only when SECOND_PEAK_EN is defined.
interface spectrum_peak_scan_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          wr_done;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_addr;
    logic          busy;
    logic          freq_valid;
    logic [AW-1:0] freq;
    logic [DW-1:0] peak_mag;
    logic          no_peak;
`ifdef SECOND_PEAK_EN
    logic [AW-1:0] freq2;
    logic [DW-1:0] peak_mag2;

    modport master (
        input  wr_done, rd_data,
        output rd_addr, busy, freq_valid, freq, peak_mag, no_peak, freq2, peak_mag2
    );
    modport slave (
        output wr_done, rd_data,
        input  rd_addr, busy, freq_valid, freq, peak_mag, no_peak, freq2, peak_mag2
    );
`else
    modport master (
        input  wr_done, rd_data,
        output rd_addr, busy, freq_valid, freq, peak_mag, no_peak
    );
    modport slave (
        output wr_done, rd_data,
        input  rd_addr, busy, freq_valid, freq, peak_mag, no_peak
    );
`endif
endinterface

// File: rtl/spectrum_peak_scan.sv
// Scans bins START_BIN..END_BIN of the FFT magnitude RAM and reports the largest bin.
// Optional second-largest tracking is enabled by defining SECOND_PEAK_EN.
module spectrum_peak_scan #(
    parameter int DW        = 16,
    parameter int AW        = 8,
    parameter int START_BIN = 1,
    parameter int END_BIN   = 120,
    parameter int RD_LAT    = 1,
    parameter int THRESH    = 0
) (
    input  logic                clk_256k,
    input  logic                rst_n,
    spectrum_peak_scan_if.master bus
);

    localparam logic [DW-1:0] THR       = DW'(THRESH);
    localparam logic [AW-1:0] FIRST_BIN = AW'(START_BIN);
    localparam logic [AW-1:0] LAST_BIN  = AW'(END_BIN);
    localparam logic [2:0]    DRAIN_LEN = 3'(RD_LAT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_start;
    logic          w_finish;
    logic          w_trig;
    logic          w_last_addr;
    logic          w_drain_end;
    logic          w_cmp;
    logic [AW-1:0] w_cmp_addr;

    logic          r_wr_done_q;
    logic [AW-1:0] r_rd_addr;
    logic          r_busy;
    logic [2:0]    r_drain_cnt;
    logic          r_vld_p [RD_LAT];
    logic [AW-1:0] r_addr_p [RD_LAT];

    logic [DW-1:0] r_max;
    logic [AW-1:0] r_idx;
    logic          r_found;
    logic          r_freq_valid;
    logic [AW-1:0] r_freq;
    logic [DW-1:0] r_peak_mag;
    logic          r_no_peak;

    function automatic logic f_beats(input logic [DW-1:0] sample, input logic [DW-1:0] cur);
        return (sample > cur) && (sample > THR);
    endfunction

    assign w_trig      = bus.wr_done & ~r_wr_done_q;
    assign w_last_addr = (r_rd_addr == LAST_BIN);
    assign w_drain_end = (r_drain_cnt == DRAIN_LEN);
    assign w_cmp       = r_vld_p[RD_LAT-1];
    assign w_cmp_addr  = r_addr_p[RD_LAT-1];

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_trig) begin
                    w_state_nxt = S_ISSUE;
                    w_start     = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_last_addr) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drain_end) begin
                    w_state_nxt = S_DONE;
                    w_finish    = 1'b1;
                end
            end
        endcase
    end

    // Stage p0: address issue and control state
    always_ff @(posedge clk_256k or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_done_q <= 1'b0;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_drain_cnt <= '0;
            for (int i = 0; i < RD_LAT; i++) r_vld_p[i] <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_done_q <= bus.wr_done;
            r_vld_p[0]  <= (r_state == S_ISSUE);
            for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
            if (w_start) begin
                r_rd_addr <= FIRST_BIN;
                r_busy    <= 1'b1;
            end else if (r_state == S_ISSUE && !w_last_addr) begin
                r_rd_addr <= r_rd_addr + AW'(1);
            end
            if (w_finish) r_busy <= 1'b0;
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 3'd1 : 3'd0;
        end
    end

    // Stage p1..pRD_LAT: address travels with the RAM read latency
    always_ff @(posedge clk_256k) begin
        r_addr_p[0] <= r_rd_addr;
        for (int i = 1; i < RD_LAT; i++) r_addr_p[i] <= r_addr_p[i-1];
    end

`ifdef SECOND_PEAK_EN
    logic [DW-1:0] r_max2;
    logic [AW-1:0] r_idx2;
    logic [AW-1:0] r_freq2;
    logic [DW-1:0] r_peak_mag2;

    always_ff @(posedge clk_256k or negedge rst_n) begin
        if (!rst_n) begin
            r_max2      <= '0;
            r_idx2      <= '0;
            r_freq2     <= '0;
            r_peak_mag2 <= '0;
        end else begin
            if (w_start) begin
                r_max2 <= '0;
                r_idx2 <= FIRST_BIN;
            end else if (w_cmp) begin
                // A displaced maximum becomes the runner-up
                if (f_beats(bus.rd_data, r_max)) begin
                    r_max2 <= r_max;
                    r_idx2 <= r_idx;
                end else if (f_beats(bus.rd_data, r_max2)) begin
                    r_max2 <= bus.rd_data;
                    r_idx2 <= w_cmp_addr;
                end
            end
            if (w_finish) begin
                r_freq2     <= r_idx2;
                r_peak_mag2 <= r_max2;
            end
        end
    end

    assign bus.freq2     = r_freq2;
    assign bus.peak_mag2 = r_peak_mag2;
`endif

    // Stage compare and result latch
    always_ff @(posedge clk_256k or negedge rst_n) begin
        if (!rst_n) begin
            r_max        <= '0;
            r_idx        <= '0;
            r_found      <= 1'b0;
            r_freq_valid <= 1'b0;
            r_freq       <= '0;
            r_peak_mag   <= '0;
            r_no_peak    <= 1'b0;
        end else begin
            if (w_start) begin
                r_max        <= '0;
                r_idx        <= FIRST_BIN;
                r_found      <= 1'b0;
                r_freq_valid <= 1'b0;
                r_no_peak    <= 1'b0;
            end else if (w_cmp && f_beats(bus.rd_data, r_max)) begin
                r_max   <= bus.rd_data;
                r_idx   <= w_cmp_addr;
                r_found <= 1'b1;
            end
            if (w_finish) begin
                r_freq       <= r_idx;
                r_peak_mag   <= r_max;
                r_no_peak    <= ~r_found;
                r_freq_valid <= 1'b1;
            end
        end
    end

    assign bus.rd_addr    = r_rd_addr;
    assign bus.busy       = r_busy;
    assign bus.freq_valid = r_freq_valid;
    assign bus.freq       = r_freq;
    assign bus.peak_mag   = r_peak_mag;
    assign bus.no_peak    = r_no_peak;

endmodule

// File: tb/tb_spectrum_peak_scan.sv
// Self-checking bench for spectrum_peak_scan: table of RAM patterns plus reset/re-trigger sequences.
// Second-peak outputs are checked when SECOND_PEAK_EN is defined.
module tb_spectrum_peak_scan;

    localparam int DW = 16;
    localparam int AW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    logic          wr [3];

    spectrum_peak_scan_if #(.DW(DW), .AW(AW)) b0 ();
    spectrum_peak_scan_if #(.DW(DW), .AW(AW)) b1 ();
    spectrum_peak_scan_if #(.DW(DW), .AW(AW)) b2 ();

    spectrum_peak_scan #(.DW(DW), .AW(AW)) u0 (.clk_256k(clk), .rst_n(rst_n), .bus(b0));
    spectrum_peak_scan #(.DW(DW), .AW(AW), .RD_LAT(3), .THRESH(16'h0100))
        u1 (.clk_256k(clk), .rst_n(rst_n), .bus(b1));
    spectrum_peak_scan #(.DW(DW), .AW(AW), .START_BIN(7), .END_BIN(7), .RD_LAT(2))
        u2 (.clk_256k(clk), .rst_n(rst_n), .bus(b2));

    // RAM models with read latency 1, 3 and 2
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1 [3];
    logic [DW-1:0] rd2 [2];
    always_ff @(posedge clk) begin
        rd0    <= mem[b0.rd_addr];
        rd1[0] <= mem[b1.rd_addr];
        rd1[1] <= rd1[0];
        rd1[2] <= rd1[1];
        rd2[0] <= mem[b2.rd_addr];
        rd2[1] <= rd2[0];
    end
    assign b0.rd_data = rd0;
    assign b1.rd_data = rd1[2];
    assign b2.rd_data = rd2[1];
    assign b0.wr_done = wr[0];
    assign b1.wr_done = wr[1];
    assign b2.wr_done = wr[2];

    // {rd_addr, busy, freq_valid, no_peak, freq, peak_mag}
    logic [34:0] pk [3];
    assign pk[0] = {b0.rd_addr, b0.busy, b0.freq_valid, b0.no_peak, b0.freq, b0.peak_mag};
    assign pk[1] = {b1.rd_addr, b1.busy, b1.freq_valid, b1.no_peak, b1.freq, b1.peak_mag};
    assign pk[2] = {b2.rd_addr, b2.busy, b2.freq_valid, b2.no_peak, b2.freq, b2.peak_mag};
`ifdef SECOND_PEAK_EN
    logic [23:0] pk2 [3];
    assign pk2[0] = {b0.freq2, b0.peak_mag2};
    assign pk2[1] = {b1.freq2, b1.peak_mag2};
    assign pk2[2] = {b2.freq2, b2.peak_mag2};
`endif

    int          cur;
    logic [34:0] cp;
    always_comb begin
        cp = pk[0];
        if (cur == 1) cp = pk[1];
        else if (cur == 2) cp = pk[2];
    end

    typedef struct {
        int          inst;
        logic [15:0] fill;
        bit          ident;
        int          b_a; logic [15:0] v_a;
        int          b_b; logic [15:0] v_b;
        int          b_c; logic [15:0] v_c;
        bit          hold;
        bit          repulse;
        logic [7:0]  e_freq; logic [15:0] e_mag; logic e_np; int e_lat;
        logic [7:0]  e_freq2; logic [15:0] e_mag2;
    } vec_t;

    typedef struct {
        logic [7:0]  f;
        logic [15:0] m;
        logic        np;
        int          lat;
        logic [7:0]  f2;
        logic [15:0] m2;
    } exp_t;

    vec_t vecs [9];
    exp_t sb_q [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic fill_mem(input vec_t v);
        for (int a = 0; a < 256; a++) mem[a] = v.ident ? DW'(a) : v.fill;
        if (v.b_a >= 0) mem[v.b_a] = v.v_a;
        if (v.b_b >= 0) mem[v.b_b] = v.v_b;
        if (v.b_c >= 0) mem[v.b_c] = v.v_c;
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        exp_t e;
        int   k;
        int   blow;
        v = vecs[vi];
        fill_mem(v);
        cur = v.inst;
        @(negedge clk);
        wr[v.inst] = 1'b1;
        e.f = v.e_freq; e.m = v.e_mag; e.np = v.e_np; e.lat = v.e_lat;
        e.f2 = v.e_freq2; e.m2 = v.e_mag2;
        sb_q.push_back(e);
        @(posedge clk);
        k    = 0;
        blow = 0;
        @(negedge clk);
        chk($sformatf("v%0d_trig_accept", vi), {cp[25], cp[26]}, 2'b01);
        while (!cp[25] && k < 400) begin
            if (!cp[26]) blow++;
            if (!v.hold && k == 2) wr[v.inst] = 1'b0;
            if (v.repulse && k == 40) wr[v.inst] = 1'b1;
            if (v.repulse && k == 44) wr[v.inst] = 1'b0;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        chk($sformatf("v%0d_latency", vi), k, e.lat);
        chk($sformatf("v%0d_busy_in_scan", vi), blow, 0);
        chk($sformatf("v%0d_busy_done", vi), cp[26], 1'b0);
        chk($sformatf("v%0d_freq", vi), cp[23:16], e.f);
        chk($sformatf("v%0d_peak_mag", vi), cp[15:0], e.m);
        chk($sformatf("v%0d_no_peak", vi), cp[24], e.np);
`ifdef SECOND_PEAK_EN
        chk($sformatf("v%0d_freq2", vi), pk2[cur][23:16], e.f2);
        chk($sformatf("v%0d_peak_mag2", vi), pk2[cur][15:0], e.m2);
`endif
        if (v.hold) begin
            repeat (10) @(negedge clk);
            chk($sformatf("v%0d_hold_one_scan", vi), {cp[25], cp[26]}, 2'b10);
            wr[v.inst] = 1'b0;
        end
        if (v.repulse) begin
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_no_queue", vi), cp[26], 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          inst fill     id  b_a va        b_b vb        b_c vc       hold rep  freq mag      np lat  f2  m2
        vecs[0] = '{0, 16'h0000, 1, 50, 16'hFFFF, -1, 16'h0,    -1, 16'h0,    0, 0, 50,  16'hFFFF, 0, 122, 120, 16'h0078};
        vecs[1] = '{0, 16'h0005, 0, 30, 16'h1000, 70, 16'h1000, 0,  16'hFFFF, 0, 0, 30,  16'h1000, 0, 122, 70,  16'h1000};
        vecs[2] = '{1, 16'h0080, 0, -1, 16'h0,    -1, 16'h0,    -1, 16'h0,    0, 0, 1,   16'h0000, 1, 124, 1,   16'h0000};
        vecs[3] = '{1, 16'h0000, 1, 120,16'h8000, -1, 16'h0,    -1, 16'h0,    0, 1, 120, 16'h8000, 0, 124, 1,   16'h0000};
        vecs[4] = '{0, 16'h0005, 0, 10, 16'd900,  20, 16'd800,  5,  16'd700,  0, 0, 10,  16'd900,  0, 122, 20,  16'd800};
        vecs[5] = '{2, 16'h0003, 0, 7,  16'h1234, -1, 16'h0,    -1, 16'h0,    0, 0, 7,   16'h1234, 0, 4,   7,   16'h0000};
        vecs[6] = '{2, 16'h0000, 0, -1, 16'h0,    -1, 16'h0,    -1, 16'h0,    1, 0, 7,   16'h0000, 1, 4,   7,   16'h0000};
        vecs[7] = '{0, 16'h0000, 0, -1, 16'h0,    -1, 16'h0,    -1, 16'h0,    0, 0, 1,   16'h0000, 1, 122, 1,   16'h0000};
        vecs[8] = '{0, 16'h0005, 0, 1,  16'h7000, 121,16'hFFFF, -1, 16'h0,    0, 0, 1,   16'h7000, 0, 122, 2,   16'h0005};

        cur = 0;
        for (int i = 0; i < 3; i++) wr[i] = 1'b0;
        fill_mem(vecs[7]);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("reset_state_u%0d", i), pk[i], 35'd0);
`ifdef SECOND_PEAK_EN
        for (int i = 0; i < 3; i++) chk($sformatf("reset_second_u%0d", i), pk2[i], 24'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i);

        // Reset in the middle of a scan, then a clean rescan
        fill_mem(vecs[0]);
        cur = 0;
        @(negedge clk);
        wr[0] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 2) wr[0] = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        chk("rst_pre_busy", cp[26], 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_clear", pk[0], 35'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_result", {cp[25], cp[26]}, 2'b00);
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
